// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD instruction queue:
//   - bit positions of the {RS, RWB, DB[7:0]} instruction word
//   - FSM state encoding of the queue front-end
//   - the FIFO entry layout {sel, instr}
//   - helpers that build the high/low nibble transfers for 4-bit mode
// -----------------------------------------------------------------------------
package lcd_pkg;

  localparam int INSTR_W   = 10;   // {RS, RWB, DB[7:0]}
  localparam int RS_BIT    = 9;
  localparam int RWB_BIT   = 8;
  localparam int DB_MSB    = 7;
  localparam int DB_LSB    = 0;
  localparam int MAX_SEL_W = 3;    // enough for up to 8 panels

  localparam logic [INSTR_W-1:0] NOP_CMD = 10'h000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_HI = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_SEND_LO = 3'd3,
    ST_WAIT_LO = 3'd4
  } lcd_q_state_e;

  typedef struct packed {
    logic [MAX_SEL_W-1:0] sel;
    logic [INSTR_W-1:0]   instr;
  } lcd_entry_t;

  // First nibble transfer: control bits plus DB[7:4] on the upper data lines.
  function automatic logic [INSTR_W-1:0] hi_xfer(input logic [INSTR_W-1:0] instr);
    return {instr[RS_BIT], instr[RWB_BIT], instr[7:4], 4'b0000};
  endfunction

  // Second nibble transfer: control bits plus DB[3:0] on the upper data lines.
  function automatic logic [INSTR_W-1:0] lo_xfer(input logic [INSTR_W-1:0] instr);
    return {instr[RS_BIT], instr[RWB_BIT], instr[3:0], 4'b0000};
  endfunction

endpackage

// File: rtl/lcd_sync_fifo.sv
// -----------------------------------------------------------------------------
// lcd_sync_fifo
// Synchronous FIFO with wrap-bit pointers and a synchronous flush.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   push_i, wdata_i write request and data (ignored when full or flushing)
//   pop_i, rdata_o  read request and head-of-queue data (show-ahead)
//   flush_i         clears both pointers; wins over a simultaneous push
//   level_o         occupancy, full_o / empty_o status
// -----------------------------------------------------------------------------
module lcd_sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic             flush_i,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o;

  // Full when the index bits match but the wrap bits differ.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; flush returns both pointers to zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/lcd_instr_queue.sv
// -----------------------------------------------------------------------------
// lcd_instr_queue
// Instruction front-end between the register block and the HD44780U PHY.
// Queues {display select, instruction}, issues each instruction to the PHY as
// one 8-bit transfer or two nibble transfers, drives the one-hot E-line select
// and returns read data as a one-cycle valid pulse.
// Ports:
//   instr_i/disp_sel_i/valid_i/ready_o   enqueue side
//   enable_i, mode_4bit_i, flush_i        control
//   phy_instr_o/phy_valid_o/phy_ready_i   PHY request handshake
//   phy_rdata_i                           PHY read data
//   disp_en_o                             one-hot panel select
//   rdata_o/rdata_valid_o                 assembled read byte
//   level_o/empty_o/full_o                FIFO status
//   sel_err_o                             sticky out-of-range select flag
// DATA_WIDTH must be 8 and INSTR_WIDTH must be 10.
// -----------------------------------------------------------------------------
module lcd_instr_queue
  import lcd_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int INSTR_WIDTH  = 10,
  parameter int DEPTH        = 8,
  parameter int NUM_DISPLAYS = 2,
  localparam int SEL_W = (NUM_DISPLAYS > 1) ? $clog2(NUM_DISPLAYS) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [INSTR_WIDTH-1:0]  instr_i,
  input  logic [SEL_W-1:0]        disp_sel_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    enable_i,
  input  logic                    mode_4bit_i,
  input  logic                    flush_i,
  output logic [INSTR_WIDTH-1:0]  phy_instr_o,
  output logic                    phy_valid_o,
  input  logic                    phy_ready_i,
  input  logic [DATA_WIDTH-1:0]   phy_rdata_i,
  output logic [NUM_DISPLAYS-1:0] disp_en_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rdata_valid_o,
  output logic [LVL_W-1:0]        level_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic                    sel_err_o
);

  lcd_entry_t              push_entry;
  lcd_entry_t              head_entry;
  logic                    sel_ok;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [LVL_W-1:0]        level;

  lcd_q_state_e            state_q;
  lcd_entry_t              cur_q;
  logic                    mode4_q;
  logic [3:0]              hi_nib_q;
  logic                    phy_valid_q;
  logic [INSTR_WIDTH-1:0]  phy_instr_q;
  logic [NUM_DISPLAYS-1:0] disp_en_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rdata_valid_q;
  logic                    sel_err_q;

  function automatic logic [NUM_DISPLAYS-1:0] sel_onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [NUM_DISPLAYS-1:0] oh;
    oh = {NUM_DISPLAYS{1'b0}};
    for (int i = 0; i < NUM_DISPLAYS; i++) oh[i] = (sel == MAX_SEL_W'(i));
    return oh;
  endfunction

  // Range-check the select; anything past the last panel is stored as panel 0.
  always_comb begin
    sel_ok           = 1'b0;
    push_entry.sel   = {MAX_SEL_W{1'b0}};
    push_entry.instr = instr_i;
    for (int i = 0; i < NUM_DISPLAYS; i++) begin
      sel_ok         = sel_ok | (disp_sel_i == SEL_W'(i));
      push_entry.sel = (disp_sel_i == SEL_W'(i)) ? MAX_SEL_W'(i) : push_entry.sel;
    end
  end

  assign push = valid_i & ~full & ~flush_i;
  assign pop  = (state_q == ST_IDLE) & enable_i & ~empty & phy_ready_i;

  lcd_sync_fifo #(
    .WIDTH ($bits(lcd_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .flush_i (flush_i),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Transfer FSM with registered PHY, E-line and read-data outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cur_q         <= '{sel: {MAX_SEL_W{1'b0}}, instr: NOP_CMD};
      mode4_q       <= 1'b0;
      hi_nib_q      <= 4'h0;
      phy_valid_q   <= 1'b0;
      phy_instr_q   <= NOP_CMD;
      disp_en_q     <= {NUM_DISPLAYS{1'b0}};
      rdata_q       <= {DATA_WIDTH{1'b0}};
      rdata_valid_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      if (valid_i && !full && !sel_ok) sel_err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            cur_q       <= head_entry;
            mode4_q     <= mode_4bit_i;
            phy_valid_q <= 1'b1;
            phy_instr_q <= mode_4bit_i ? hi_xfer(head_entry.instr) : head_entry.instr;
            disp_en_q   <= sel_onehot(head_entry.sel);
            state_q     <= ST_SEND_HI;
          end
        end
        ST_SEND_HI: begin
          // phy_valid_q is high here, so phy_ready_i alone marks acceptance.
          if (phy_ready_i) begin
            phy_valid_q <= 1'b0;
            state_q     <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (phy_ready_i) begin
            if (mode4_q) begin
              hi_nib_q    <= phy_rdata_i[7:4];
              phy_valid_q <= 1'b1;
              phy_instr_q <= lo_xfer(cur_q.instr);
              state_q     <= ST_SEND_LO;
            end else begin
              if (cur_q.instr[RWB_BIT]) begin
                rdata_q       <= phy_rdata_i;
                rdata_valid_q <= 1'b1;
              end
              phy_instr_q <= NOP_CMD;
              disp_en_q   <= {NUM_DISPLAYS{1'b0}};
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_SEND_LO: begin
          if (phy_ready_i) begin
            phy_valid_q <= 1'b0;
            state_q     <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (phy_ready_i) begin
            if (cur_q.instr[RWB_BIT]) begin
              rdata_q       <= {hi_nib_q, phy_rdata_i[7:4]};
              rdata_valid_q <= 1'b1;
            end
            phy_instr_q <= NOP_CMD;
            disp_en_q   <= {NUM_DISPLAYS{1'b0}};
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          phy_valid_q <= 1'b0;
          phy_instr_q <= NOP_CMD;
          disp_en_q   <= {NUM_DISPLAYS{1'b0}};
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o       = ~full;
  assign full_o        = full;
  assign empty_o       = empty;
  assign level_o       = level;
  assign phy_valid_o   = phy_valid_q;
  assign phy_instr_o   = phy_instr_q;
  assign disp_en_o     = disp_en_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign sel_err_o     = sel_err_q;

endmodule

// File: tb/tb_lcd_instr_queue.sv
// -----------------------------------------------------------------------------
// tb_lcd_instr_queue
// Directed self-checking bench for lcd_instr_queue (DEPTH=8, 2 displays).
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lcd_instr_queue;

  localparam int DW = 8;
  localparam int IW = 10;
  localparam int DEPTH = 8;
  localparam int ND = 2;
  localparam int SEL_W = 1;
  localparam int LW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [IW-1:0] instr_i;
  logic [SEL_W-1:0] disp_sel_i;
  logic          valid_i;
  logic          ready_o;
  logic          enable_i;
  logic          mode_4bit_i;
  logic          flush_i;
  logic [IW-1:0] phy_instr_o;
  logic          phy_valid_o;
  logic          phy_ready_i;
  logic [DW-1:0] phy_rdata_i;
  logic [ND-1:0] disp_en_o;
  logic [DW-1:0] rdata_o;
  logic          rdata_valid_o;
  logic [LW-1:0] level_o;
  logic          empty_o;
  logic          full_o;
  logic          sel_err_o;

  always #5 clk_i = ~clk_i;

  lcd_instr_queue #(
    .DATA_WIDTH(DW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .NUM_DISPLAYS(ND)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_i(instr_i), .disp_sel_i(disp_sel_i),
    .valid_i(valid_i), .ready_o(ready_o), .enable_i(enable_i),
    .mode_4bit_i(mode_4bit_i), .flush_i(flush_i), .phy_instr_o(phy_instr_o),
    .phy_valid_o(phy_valid_o), .phy_ready_i(phy_ready_i), .phy_rdata_i(phy_rdata_i),
    .disp_en_o(disp_en_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .level_o(level_o), .empty_o(empty_o), .full_o(full_o), .sel_err_o(sel_err_o)
  );

  int checks = 0;
  int errors = 0;
  int rv_cnt = 0;
  logic [11:0] hs_log[$];   // {disp_en, phy_instr} of each accepted PHY request

  // Record every PHY handshake and every read-data pulse.
  always @(posedge clk_i) begin
    if (rst_ni && phy_valid_o && phy_ready_i) hs_log.push_back({disp_en_o, phy_instr_o});
    if (rdata_valid_o) rv_cnt <= rv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    int base;
    int rv0;
    logic done;
    logic [11:0] exp_e;

    rst_ni = 1'b0; instr_i = 10'h000; disp_sel_i = 1'b0; valid_i = 1'b0;
    enable_i = 1'b0; mode_4bit_i = 1'b0; flush_i = 1'b0;
    phy_ready_i = 1'b0; phy_rdata_i = 8'h00;
    step(2);
    rst_ni = 1'b1;

    // ---- Reset with a non-empty FIFO ----
    valid_i = 1'b1; instr_i = 10'h155;
    step(2);
    valid_i = 1'b0;
    chk("pre_reset_level", level_o, 2);
    rst_ni = 1'b0;
    step(1);
    chk("rst_level", level_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_sel_err", sel_err_o, 0);
    chk("rst_phy_valid", phy_valid_o, 0);
    chk("rst_phy_instr", phy_instr_o, 0);
    chk("rst_disp_en", disp_en_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_rdata_valid", rdata_valid_o, 0);
    rst_ni = 1'b1;
    step(1);

    // ---- 8-bit write 0x038 to display 1 ----
    enable_i = 1'b1; mode_4bit_i = 1'b0; phy_ready_i = 1'b1;
    base = hs_log.size(); rv0 = rv_cnt;
    valid_i = 1'b1; instr_i = 10'h038; disp_sel_i = 1'b1;
    step(1);
    valid_i = 1'b0;
    chk("w8_lat_valid0", phy_valid_o, 0);
    chk("w8_level1", level_o, 1);
    step(1);
    chk("w8_valid", phy_valid_o, 1);
    chk("w8_instr", phy_instr_o, 10'h038);
    chk("w8_disp_en", disp_en_o, 2'b10);
    step(1);
    chk("w8_wait_valid", phy_valid_o, 0);
    chk("w8_wait_disp_en", disp_en_o, 2'b10);
    step(1);
    chk("w8_idle_disp_en", disp_en_o, 0);
    chk("w8_hs_count", hs_log.size() - base, 1);
    chk("w8_no_rdata", rv_cnt - rv0, 0);

    // ---- 4-bit write 0x2A5 with PHY stall; mode input changes mid-instruction ----
    base = hs_log.size();
    mode_4bit_i = 1'b1;
    valid_i = 1'b1; instr_i = 10'h2A5; disp_sel_i = 1'b0;
    step(1);
    valid_i = 1'b0;
    step(1);
    chk("w4_hi_valid", phy_valid_o, 1);
    chk("w4_hi_instr", phy_instr_o, 10'h2A0);
    chk("w4_disp_en", disp_en_o, 2'b01);
    phy_ready_i = 1'b0; mode_4bit_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("w4_stall_valid", phy_valid_o, 1);
      chk("w4_stall_instr", phy_instr_o, 10'h2A0);
    end
    phy_ready_i = 1'b1;
    step(1);
    chk("w4_waithi_valid", phy_valid_o, 0);
    step(1);
    chk("w4_lo_valid", phy_valid_o, 1);
    chk("w4_lo_instr", phy_instr_o, 10'h250);
    chk("w4_lo_disp_en", disp_en_o, 2'b01);
    step(2);
    chk("w4_done_disp_en", disp_en_o, 0);
    chk("w4_hs_count", hs_log.size() - base, 2);
    chk("w4_hs_first", hs_log[base], {2'b01, 10'h2A0});
    chk("w4_hs_second", hs_log[base+1], {2'b01, 10'h250});

    // ---- 4-bit read 0x1FF, PHY returns 0xB0 then 0x70 ----
    base = hs_log.size(); rv0 = rv_cnt;
    mode_4bit_i = 1'b1; phy_rdata_i = 8'hB0;
    valid_i = 1'b1; instr_i = 10'h1FF; disp_sel_i = 1'b0;
    step(1);
    valid_i = 1'b0;
    step(1);
    chk("r4_hi_instr", phy_instr_o, 10'h1F0);
    step(1);
    chk("r4_waithi_valid", phy_valid_o, 0);
    step(1);
    chk("r4_lo_valid", phy_valid_o, 1);
    chk("r4_no_early_pulse", rdata_valid_o, 0);
    phy_rdata_i = 8'h70;
    step(2);
    chk("r4_pulse", rdata_valid_o, 1);
    chk("r4_rdata", rdata_o, 8'hB7);
    step(1);
    chk("r4_pulse_end", rdata_valid_o, 0);
    chk("r4_rdata_hold", rdata_o, 8'hB7);
    step(1);
    chk("r4_pulse_count", rv_cnt - rv0, 1);
    chk("r4_hs_count", hs_log.size() - base, 2);

    // ---- 8-bit read 0x1A0 from display 1, PHY returns 0x5C ----
    rv0 = rv_cnt;
    mode_4bit_i = 1'b0; phy_rdata_i = 8'h5C;
    valid_i = 1'b1; instr_i = 10'h1A0; disp_sel_i = 1'b1;
    step(1);
    valid_i = 1'b0;
    step(3);
    chk("r8_pulse", rdata_valid_o, 1);
    chk("r8_rdata", rdata_o, 8'h5C);
    step(2);
    chk("r8_pulse_count", rv_cnt - rv0, 1);

    // ---- Fill to full with enable low, then drain in order ----
    enable_i = 1'b0; mode_4bit_i = 1'b0; phy_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      valid_i = 1'b1; instr_i = 10'h010 + 10'(i); disp_sel_i = 1'(i % 2);
      step(1);
      if (i == 7) begin
        chk("fill_full", full_o, 1);
        chk("fill_ready", ready_o, 0);
        chk("fill_level8", level_o, 8);
      end
    end
    valid_i = 1'b0;
    chk("fill_ninth_dropped", level_o, 8);
    base = hs_log.size();
    enable_i = 1'b1;
    step(1);
    chk("drain_level7", level_o, 7);
    chk("drain_not_full", full_o, 0);
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      step(1);
      if ((hs_log.size() - base) >= 8 && !phy_valid_o && disp_en_o == 2'b00) done = 1'b1;
    end
    chk("drain_done", done, 1);
    chk("drain_hs_count", hs_log.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      exp_e = {((i % 2) == 1) ? 2'b10 : 2'b01, 10'h010 + 10'(i)};
      chk("drain_order", hs_log[base+i], exp_e);
    end
    chk("drain_level0", level_o, 0);
    chk("drain_empty", empty_o, 1);

    // ---- Flush during SEND_LO with 3 entries queued behind ----
    enable_i = 1'b0; mode_4bit_i = 1'b1;
    valid_i = 1'b1; instr_i = 10'h2C3; disp_sel_i = 1'b0;
    step(1);
    instr_i = 10'h011; disp_sel_i = 1'b1; step(1);
    instr_i = 10'h022; step(1);
    instr_i = 10'h033; step(1);
    valid_i = 1'b0;
    chk("fl_level4", level_o, 4);
    base = hs_log.size();
    enable_i = 1'b1;
    step(1);
    enable_i = 1'b0;
    chk("fl_hi_instr", phy_instr_o, 10'h2C0);
    chk("fl_level3", level_o, 3);
    step(2);
    chk("fl_lo_valid", phy_valid_o, 1);
    chk("fl_lo_instr", phy_instr_o, 10'h230);
    phy_ready_i = 1'b0; flush_i = 1'b1;
    valid_i = 1'b1; instr_i = 10'h3FF;
    step(1);
    flush_i = 1'b0; valid_i = 1'b0;
    chk("fl_level0", level_o, 0);
    chk("fl_empty", empty_o, 1);
    chk("fl_lo_still_valid", phy_valid_o, 1);
    chk("fl_lo_still_instr", phy_instr_o, 10'h230);
    phy_ready_i = 1'b1; enable_i = 1'b1;
    step(6);
    chk("fl_idle_valid", phy_valid_o, 0);
    chk("fl_idle_disp_en", disp_en_o, 0);
    chk("fl_hs_count", hs_log.size() - base, 2);
    chk("fl_lo_logged", hs_log[base+1], {2'b01, 10'h230});
    chk("fl_final_empty", empty_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_instr_queue.md
Name: lcd_instr_queue

Overview:
- Parametrised instruction front-end between the register block and the HD44780U PHY.
- Buffers LCD instructions in a DEPTH-entry FIFO and routes each one to one of NUM_DISPLAYS panels that share the bus.
- Optionally splits each instruction into two nibble transfers for 4-bit interface mode, and reassembles the nibbles on reads.
- Returns read-back data (busy flag/address, CGRAM/DDRAM data) through a valid-qualified output.

Parameters:
- DATA_WIDTH, 8, LCD data bus width; must be 8.
- INSTR_WIDTH, 10, instruction width {RS, RWB, DB[7:0]}; equals DATA_WIDTH+2.
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- NUM_DISPLAYS, 2, panel count, 1..8; SEL_W = max(1, $clog2(NUM_DISPLAYS)).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; synchronous, active-low.
- instr_i  in  INSTR_WIDTH  instruction to enqueue.
- disp_sel_i  in  SEL_W  target display index.
- valid_i  in  1  enqueue request.
- ready_o  out  1  FIFO not full.
- enable_i  in  1  allow new instructions to start.
- mode_4bit_i  in  1  1 = nibble mode.
- flush_i  in  1  discard queued entries.
- phy_instr_o  out  INSTR_WIDTH  instruction to PHY.
- phy_valid_o  out  1  PHY request.
- phy_ready_i  in  1  PHY ready/idle.
- phy_rdata_i  in  DATA_WIDTH  PHY read data.
- disp_en_o  out  NUM_DISPLAYS  one-hot E-line select for the active instruction.
- rdata_o  out  DATA_WIDTH  assembled read byte.
- rdata_valid_o  out  1  one-cycle pulse.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- sel_err_o  out  1  sticky: disp_sel_i >= NUM_DISPLAYS was seen on a push.

Behaviour:
- Reset values (rst_ni=0 at a clock edge):
  - phy_valid_o=0, phy_instr_o=0, disp_en_o=0.
  - rdata_o=0, rdata_valid_o=0.
  - level_o=0, empty_o=1, full_o=0, ready_o=1, sel_err_o=0.
  - FSM returns to IDLE.
- Reset mid-transfer abandons the transfer immediately.
- Push:
  - Occurs when valid_i & ready_o; stores {disp_sel_i, instr_i}.
  - ready_o = !full_o; there is no bypass.
  - An out-of-range select sets sel_err_o and is stored as index 0.
- FSM states: IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO.
- IDLE:
  - Leaves IDLE only if enable_i & !empty_o & phy_ready_i.
  - Pops the head entry, latches mode_4bit_i for the whole instruction, and goes to SEND_HI.
  - Latency: a push at edge N into an empty FIFO gives phy_valid_o=1 after edge N+1.
- SEND_HI:
  - phy_valid_o=1 and disp_en_o=1<<sel.
  - 8-bit mode: phy_instr_o = the entry.
  - 4-bit mode: phy_instr_o = {RS, RWB, DB[7:4], 4'b0}.
  - phy_valid_o and phy_instr_o hold stable until the cycle phy_valid_o & phy_ready_i; then go to WAIT_HI and drop phy_valid_o.
- WAIT_HI:
  - Waits for phy_ready_i=1 in a cycle after acceptance. On a read, samples phy_rdata_i at that cycle.
  - 8-bit mode: rdata_o = sample, and rdata_valid_o pulses if RWB=1. Go to IDLE.
  - 4-bit mode: store sample[7:4] as the high nibble, then go to SEND_LO.
- SEND_LO / WAIT_LO:
  - Same rules as SEND_HI / WAIT_HI, with phy_instr_o = {RS, RWB, DB[3:0], 4'b0}.
  - On a read, rdata_o = {hi, sample[7:4]} and rdata_valid_o pulses. Go to IDLE.
- disp_en_o holds from SEND_HI through the final WAIT state, then returns to 0.
- flush_i:
  - Clears the FIFO pointers next edge; level_o becomes 0.
  - The in-flight instruction, including its second nibble, still completes.
  - flush_i with a simultaneous push: flush wins and the push is discarded.
- enable_i low: blocks only the IDLE exit; the in-flight instruction completes.
- Simultaneous push and pop: allowed while not full; level_o is unchanged.
- Pointers are log2(DEPTH) bits plus a wrap bit and wrap naturally.
  - full_o = pointers differ only in the wrap bit.
  - level_o = wr_ptr - rd_ptr, modulo 2*DEPTH.

Decomposition:
- Package lcd_pkg holds:
  - RS_BIT, RWB_BIT, field positions.
  - The FSM state enum lcd_q_state_e.
  - The NOP_CMD constant.
  - A packed entry struct {sel, instr}.
- One sub-module, lcd_sync_fifo, parametrised by WIDTH and DEPTH, with push/pop/flush/level/full/empty. The FSM and nibble logic stay in the top.

Test Plan:
- Reset with a nonzero FIFO level, then hold rst_ni=0 one edge → all outputs at reset values, level_o=0, ready_o=1.
- 8-bit mode, push 0x038 (function set) to display 1, phy_ready_i=1 → phy_valid_o high after 1 edge, phy_instr_o=0x038, disp_en_o=2'b10, one PHY handshake.
- 4-bit mode, push 0x2A5 (RS=1, write 0xA5) → two handshakes with phy_instr_o=0x2A0 then 0x250; phy_instr_o stays stable while phy_ready_i is held 0 for 5 cycles.
- 4-bit read 0x1FF, PHY returns 0xB0 then 0x70 → a single rdata_valid_o pulse with rdata_o=0xB7.
- DEPTH=8: push 9 with enable_i=0 → full_o=1 after 8, ready_o=0, 9th not stored; enable_i=1 drains in FIFO order; level_o counts down to 0.
- flush_i asserted during SEND_LO with 3 queued → low nibble completes, queued 3 discarded, empty_o=1, FSM back to IDLE.
